nolinear_ctrl: RTL and testbench
================================

Name: nolinear_ctrl

Overview:
Sequencer that drives the control side of the nolinear datapath (valid, mode, s_in, s_mux, s_mult, s_add, en_add, en_mult). It accepts one job per start pulse and waits for the sorter max when needed. It issues one or two passes through the 4-stage datapath, skewing each control field to the stage that consumes it, and flags when the datapath output is final.

Parameters:
PIPE_LAT, 4, cycles from stage-1 issue to result visible on datapath out.
SORT_LAT, 4, cycles the max sorter needs after a vector is presented (softmax only).

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
start  input  1  job request, sampled only in IDLE
mode_in  input  2  00 softmax, 01 gelu, 10 silu, 11 root; sampled with start
busy  output  1  job in progress; upstream must hold the datapath vector stable while high
done  output  1  one-cycle pulse, final result valid on datapath out
start_drop  output  1  one-cycle pulse, start seen while not IDLE (request ignored)
valid  output  1  feedback enable to datapath (stage 1)
mode  output  2  latched job mode, held for the whole job
s_in  output  3  selector code (stage 1)
s_mux  output  1  ru mux select (stage 2)
s_mult  output  3  ru multiplier select (stage 2)
s_add  output  1  adder select (stage 3)
en_add  output  1  1 = bypass adder (stage 3)
en_mult  output  1  1 = bypass x-multiply (stage 4)

Behaviour:
- Reset (rst=0 at posedge): state IDLE; busy, done, start_drop, valid, s_mux, s_add = 0; mode = 00; s_in, s_mult = 0; en_add, en_mult = 1. Reset mid-job aborts immediately, and done never fires.
- FSM: IDLE -> WAIT_MAX (softmax only; exactly SORT_LAT cycles) -> ISSUE1 (1 cycle) -> DRAIN1 (PIPE_LAT-1 cycles) -> ISSUE2 (softmax/root only, 1 cycle) -> DRAIN2 (PIPE_LAT-1 cycles) -> FIN (1 cycle) -> IDLE. Gelu/silu go DRAIN1 -> FIN.
- The start edge at cycle 0 gives busy=1 from cycle 1. Issue cycle T1 = 1, or 1+SORT_LAT for softmax. T2 = T1+PIPE_LAT. The final issue Tf is T2 for 2-pass jobs and T1 otherwise.
- done = 1 only in cycle Tf+PIPE_LAT (FIN). busy stays high through that cycle and is 0 in the next.
- Pass-1 word at issue (mode: s_in/s_mult/s_add/en_add/en_mult):
  - softmax: 0/0/1/0/1
  - gelu: 1/1/0/1/0
  - silu: 2/2/0/1/0
  - root: 3/3/0/1/1
  - valid=0, s_mux=0.
- Pass-2 word: valid=1, s_mux=1, s_add=0, en_add=1, en_mult=1.
  - softmax: s_in=4, s_mult=4.
  - root: s_in=5, s_mult=5.
- Stage skew for an issue at cycle T:
  - valid and s_in active in cycle T.
  - s_mux and s_mult in T+1.
  - s_add and en_add in T+2.
  - en_mult in T+3.
- Outside its slot, each field returns to its reset value. valid is therefore high for exactly one cycle (T2), which is when the pass-1 result sits in the stage-4 register.
- The skew is built as per-stage delay registers fed from the issue word. The pass-1 tail and the pass-2 head never overlap, because T2-T1 = PIPE_LAT >= 4.
- start while busy: ignored, and start_drop pulses the next cycle. A start in the FIN cycle is also dropped. A start in the cycle after FIN is accepted.
- mode changes only on an accepted start.

Optional Feature:
- Macro NOLINEAR_CTRL_PERF_EN.
- When defined: adds output perf_jobs[15:0], which increments in each done cycle, wraps at 16'hFFFF->0, and resets to 0. Adds output perf_busy[31:0], which increments every busy cycle, saturates at all-ones, and resets to 0.
- When undefined: neither port nor its logic exists; the other behaviour is identical.

Test Plan:
- gelu: start=1, mode_in=01 at cycle 0 -> s_in=1 at 1; s_mult=1 at 2; en_add=1 at 3; en_mult=0 at 4; done=1 at 5 only; busy=1 for cycles 1-5; valid never 1.
- softmax: start at cycle 0, mode_in=00 -> s_in=0 at 5 and s_add=1, en_add=0 at 7. valid=1, s_in=4 at 9; s_mux=1, s_mult=4 at 10; done at 13.
- root: start at 0, mode_in=11 -> s_in=3 at 1, valid=1 with s_in=5 at 5, done at 9, busy low at 10.
- silu job started at 0: start pulses at cycles 3 and 5 -> start_drop at 4 and 6, single done at 5. A fresh start at 6 is accepted, with done at 11.
- Softmax started at 0, rst=0 at cycle 7 -> from cycle 8: all outputs at reset values, no done, busy=0. Start at 9 with gelu -> done at 14.
- PERF_EN: run 3 gelu jobs back-to-back -> perf_jobs=3, perf_busy=15. Preload perf_jobs=16'hFFFF via force, then one job -> 0.

Source files
------------

// File: rtl/nolinear_ctrl.sv
// Control sequencer for the nolinear datapath: one or two skewed passes per job.
// Optional macro NOLINEAR_CTRL_PERF_EN adds perf_jobs/perf_busy counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, datapath controls at rest
// WAIT_MAX | softmax only, sorter settling for SORT_LAT cycles
// ISSUE1   | pass-1 word enters stage 1
// DRAIN1   | pass-1 travelling through stages 2..4
// ISSUE2   | pass-2 word enters stage 1 (softmax/root)
// DRAIN2   | pass-2 travelling through stages 2..4
// FIN      | final result on datapath out, done asserted
module nolinear_ctrl #(
  parameter int PIPE_LAT = 4,
  parameter int SORT_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_in,
  output logic       busy,
  output logic       done,
  output logic       start_drop,
  output logic       valid,
  output logic [1:0] mode,
  output logic [2:0] s_in,
  output logic       s_mux,
  output logic [2:0] s_mult,
  output logic       s_add,
  output logic       en_add,
  output logic       en_mult
`ifdef NOLINEAR_CTRL_PERF_EN
  ,
  output logic [15:0] perf_jobs,
  output logic [31:0] perf_busy
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MAX = 3'd1,
    ISSUE1   = 3'd2,
    DRAIN1   = 3'd3,
    ISSUE2   = 3'd4,
    DRAIN2   = 3'd5,
    FIN      = 3'd6
  } state_t;

  localparam logic [1:0] MODE_SOFTMAX = 2'b00;
  localparam logic [1:0] MODE_GELU    = 2'b01;
  localparam logic [1:0] MODE_SILU    = 2'b10;
  localparam logic [1:0] MODE_ROOT    = 2'b11;

  localparam logic [7:0] SORT_LOAD  = 8'(SORT_LAT - 1);
  localparam logic [7:0] DRAIN_LOAD = 8'(PIPE_LAT - 2);

  typedef struct packed {
    logic       valid;
    logic [2:0] s_in;
    logic       s_mux;
    logic [2:0] s_mult;
    logic       s_add;
    logic       en_add;
    logic       en_mult;
  } word_t;

  localparam word_t REST_WORD = '{valid: 1'b0, s_in: 3'd0, s_mux: 1'b0, s_mult: 3'd0,
                                  s_add: 1'b0, en_add: 1'b1, en_mult: 1'b1};

  function automatic word_t pass1_word(input logic [1:0] m);
    word_t w;
    w = REST_WORD;
    unique case (m)
      MODE_SOFTMAX: begin
        w.s_in = 3'd0; w.s_mult = 3'd0; w.s_add = 1'b1; w.en_add = 1'b0; w.en_mult = 1'b1;
      end
      MODE_GELU: begin
        w.s_in = 3'd1; w.s_mult = 3'd1; w.s_add = 1'b0; w.en_add = 1'b1; w.en_mult = 1'b0;
      end
      MODE_SILU: begin
        w.s_in = 3'd2; w.s_mult = 3'd2; w.s_add = 1'b0; w.en_add = 1'b1; w.en_mult = 1'b0;
      end
      MODE_ROOT: begin
        w.s_in = 3'd3; w.s_mult = 3'd3; w.s_add = 1'b0; w.en_add = 1'b1; w.en_mult = 1'b1;
      end
      default: w = REST_WORD;
    endcase
    return w;
  endfunction

  function automatic word_t pass2_word(input logic [1:0] m);
    word_t w;
    w         = REST_WORD;
    w.valid   = 1'b1;
    w.s_mux   = 1'b1;
    w.s_in    = (m == MODE_SOFTMAX) ? 3'd4 : 3'd5;
    w.s_mult  = (m == MODE_SOFTMAX) ? 3'd4 : 3'd5;
    return w;
  endfunction

  function automatic logic is_two_pass(input logic [1:0] m);
    return (m == MODE_SOFTMAX) || (m == MODE_ROOT);
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic       drop_q, drop_d;
  word_t      issue_d;
  word_t      st1_q, st2_q, st3_q, st4_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      mode_q  <= 2'b00;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    drop_d  = start && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode_in;
          if (mode_in == MODE_SOFTMAX) begin
            state_d = WAIT_MAX;
            cnt_d   = SORT_LOAD;
          end else begin
            state_d = ISSUE1;
          end
        end
      end
      WAIT_MAX: begin
        if (cnt_q == 8'd0) state_d = ISSUE1;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ISSUE1: begin
        state_d = DRAIN1;
        cnt_d   = DRAIN_LOAD;
      end
      DRAIN1: begin
        if (cnt_q == 8'd0) state_d = is_two_pass(mode_q) ? ISSUE2 : FIN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ISSUE2: begin
        state_d = DRAIN2;
        cnt_d   = DRAIN_LOAD;
      end
      DRAIN2: begin
        if (cnt_q == 8'd0) state_d = FIN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The issue word is registered as the FSM enters an ISSUE state, so stage 1 lines up with it.
  always_comb begin
    issue_d = REST_WORD;
    if (state_d == ISSUE1)      issue_d = pass1_word(mode_d);
    else if (state_d == ISSUE2) issue_d = pass2_word(mode_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st1_q <= REST_WORD;
      st2_q <= REST_WORD;
      st3_q <= REST_WORD;
      st4_q <= REST_WORD;
    end else begin
      st1_q <= issue_d;
      st2_q <= st1_q;
      st3_q <= st2_q;
      st4_q <= st3_q;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign start_drop = drop_q;
  assign mode       = mode_q;
  assign valid      = st1_q.valid;
  assign s_in       = st1_q.s_in;
  assign s_mux      = st2_q.s_mux;
  assign s_mult     = st2_q.s_mult;
  assign s_add      = st3_q.s_add;
  assign en_add     = st3_q.en_add;
  assign en_mult    = st4_q.en_mult;

`ifdef NOLINEAR_CTRL_PERF_EN
  logic [15:0] perf_jobs_q;
  logic [31:0] perf_busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_jobs_q <= 16'd0;
      perf_busy_q <= 32'd0;
    end else begin
      if (done) perf_jobs_q <= perf_jobs_q + 16'd1;
      if (busy && (perf_busy_q != 32'hFFFF_FFFF)) perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_jobs = perf_jobs_q;
  assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_nolinear_ctrl.sv
// Bench for nolinear_ctrl: directed job scenarios plus random starts/resets
// against a per-cycle expectation timeline painted from the job timing rules.
module tb_nolinear_ctrl;
  localparam int PIPE_LAT = 4;
  localparam int SORT_LAT = 4;
  localparam int N        = 1100;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] mode_in;
  logic       busy, done, start_drop, valid, s_mux, s_add, en_add, en_mult;
  logic [1:0] mode;
  logic [2:0] s_in, s_mult;
`ifdef NOLINEAR_CTRL_PERF_EN
  logic [15:0] perf_jobs;
  logic [31:0] perf_busy;
`endif

  always #5 clk = ~clk;

  nolinear_ctrl #(.PIPE_LAT(PIPE_LAT), .SORT_LAT(SORT_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
    .busy(busy), .done(done), .start_drop(start_drop), .valid(valid),
    .mode(mode), .s_in(s_in), .s_mux(s_mux), .s_mult(s_mult),
    .s_add(s_add), .en_add(en_add), .en_mult(en_mult)
`ifdef NOLINEAR_CTRL_PERF_EN
    , .perf_jobs(perf_jobs), .perf_busy(perf_busy)
`endif
  );

  // Expected value of every output in every cycle.
  logic       e_busy[N], e_done[N], e_drop[N], e_valid[N], e_mux[N];
  logic       e_add[N], e_enadd[N], e_enmult[N];
  logic [1:0] e_mode[N];
  logic [2:0] e_sin[N], e_smult[N];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int busy_end = -1;
  int pj = 0;
  longint pb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic clear_from(input int k0);
    for (int k = k0; k < N; k++) begin
      e_busy[k] = 0; e_done[k] = 0; e_drop[k] = 0; e_valid[k] = 0; e_mux[k] = 0;
      e_add[k] = 0; e_enadd[k] = 1; e_enmult[k] = 1; e_mode[k] = 2'b00;
      e_sin[k] = 3'd0; e_smult[k] = 3'd0;
    end
  endtask

  // Job accepted with start high in cycle c.
  task automatic paint_job(input int c, input logic [1:0] m);
    int t1, t2, tf, fin;
    bit two;
    two = (m == 2'b00) || (m == 2'b11);
    t1  = c + 1 + ((m == 2'b00) ? SORT_LAT : 0);
    t2  = t1 + PIPE_LAT;
    tf  = two ? t2 : t1;
    fin = tf + PIPE_LAT;
    if (fin + 4 >= N) return;
    for (int k = c + 1; k < N; k++) e_mode[k] = m;
    for (int k = c + 1; k <= fin; k++) e_busy[k] = 1;
    e_done[fin]     = 1;
    e_sin[t1]       = {1'b0, m};
    e_smult[t1 + 1] = {1'b0, m};
    e_add[t1 + 2]   = (m == 2'b00);
    e_enadd[t1 + 2] = (m != 2'b00);
    e_enmult[t1 + 3] = two;
    if (two) begin
      e_valid[t2]      = 1;
      e_sin[t2]        = (m == 2'b00) ? 3'd4 : 3'd5;
      e_mux[t2 + 1]    = 1;
      e_smult[t2 + 1]  = (m == 2'b00) ? 3'd4 : 3'd5;
      e_add[t2 + 2]    = 0;
      e_enadd[t2 + 2]  = 1;
      e_enmult[t2 + 3] = 1;
    end
    busy_end = fin;
  endtask

  // One cycle: check this cycle's outputs, then drive inputs and advance the model.
  task automatic step(input logic st, input logic [1:0] m, input logic r);
    chk("busy",       32'(busy),       32'(e_busy[cyc]));
    chk("done",       32'(done),       32'(e_done[cyc]));
    chk("start_drop", 32'(start_drop), 32'(e_drop[cyc]));
    chk("valid",      32'(valid),      32'(e_valid[cyc]));
    chk("mode",       32'(mode),       32'(e_mode[cyc]));
    chk("s_in",       32'(s_in),       32'(e_sin[cyc]));
    chk("s_mux",      32'(s_mux),      32'(e_mux[cyc]));
    chk("s_mult",     32'(s_mult),     32'(e_smult[cyc]));
    chk("s_add",      32'(s_add),      32'(e_add[cyc]));
    chk("en_add",     32'(en_add),     32'(e_enadd[cyc]));
    chk("en_mult",    32'(en_mult),    32'(e_enmult[cyc]));
`ifdef NOLINEAR_CTRL_PERF_EN
    chk("perf_jobs",  32'(perf_jobs),  32'(pj));
    chk("perf_busy",  perf_busy,       32'(pb));
    if (e_done[cyc]) pj = (pj + 1) & 16'hFFFF;
    if (e_busy[cyc] && pb < 64'hFFFF_FFFF) pb++;
`endif
    start = st; mode_in = m; rst = r;
    if (st) begin
      if (cyc <= busy_end) e_drop[cyc + 1] = 1;
      else paint_job(cyc, m);
    end
    if (!r) begin
      clear_from(cyc + 1);
      busy_end = -1;
      pj = 0;
      pb = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    clear_from(0);
    rst = 1'b0; start = 1'b0; mode_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    // gelu: done at 5, valid never high
    step(1'b1, 2'b01, 1'b1); idle(7);
    // softmax: sorter wait then two passes, done at 13
    step(1'b1, 2'b00, 1'b1); idle(15);
    // root: two passes, done at 9
    step(1'b1, 2'b11, 1'b1); idle(11);
    // silu with drops at 3 (busy) and 5 (FIN), fresh start at 6
    step(1'b1, 2'b10, 1'b1); idle(2);
    step(1'b1, 2'b01, 1'b1); idle(1);
    step(1'b1, 2'b11, 1'b1);
    step(1'b1, 2'b10, 1'b1); idle(7);
    // softmax aborted by reset at 7, gelu at 9
    step(1'b1, 2'b00, 1'b1); idle(6);
    step(1'b0, 2'b00, 1'b0); idle(1);
    step(1'b1, 2'b01, 1'b1); idle(7);
    // three back-to-back gelu jobs from a clean reset
    step(1'b0, 2'b00, 1'b0);
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 2'b01, 1'b1); idle(5);
    end
    idle(1);
`ifdef NOLINEAR_CTRL_PERF_EN
    chk("perf_jobs_3", 32'(perf_jobs), 32'd3);
    chk("perf_busy_15", perf_busy, 32'd15);
    force dut.perf_jobs_q = 16'hFFFF;
    #1;
    release dut.perf_jobs_q;
    pj = 16'hFFFF;
    step(1'b1, 2'b10, 1'b1); idle(6);
    chk("perf_jobs_wrap", 32'(perf_jobs), 32'd0);
`endif
    // random traffic with occasional resets
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) != 0));
    end
    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
